// File: rtl/spi_regbank_burst.sv
// SPI mode-0 slave register bank with burst auto-increment, abort counting and write strobe.
// All SPI pins are synchronised into theClock; the host must hold SCLK high/low >= 4 cycles.
module spi_regbank_burst #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 15,
   parameter int N_CH    = 18,
   parameter int IO_BASE = 16
) (
   input  logic                     theClock,
   input  logic                     theReset,
   input  logic                     MySPI_clk,
   input  logic                     MySPI_cs,
   input  logic                     MySPI_sdi,
   output logic                     MySPI_sdo,
   output logic [DATA_W-1:0]        Config,
   input  logic [DATA_W-1:0]        Status,
   output logic [DATA_W-1:0]        Led70,
   input  logic [N_CH*DATA_W-1:0]   IO_Data_In,
   output logic [N_CH*DATA_W-1:0]   IO_Data_Out,
   output logic [N_CH*DATA_W-1:0]   IO_Enable_Out,
   output logic                     Wr_Strobe,
   output logic [ADDR_W-1:0]        Wr_Addr,
   output logic [7:0]               Frame_Err_Cnt
);

   localparam int CMD_BITS = ADDR_W + 1;
   localparam int MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
   localparam int CNT_W    = $clog2(MAX_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_LOAD,
      S_DATA,
      S_COMMIT
   } state_t;

   state_t state_q, state_d;

   logic [1:0] sclk_sync, cs_sync, sdi_sync;
   logic       sclk_prev, cs_prev;
   logic       sclk_rise, cs_high, cs_fall, sdi_s;

   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] sr_q;
   logic [CNT_W-1:0]  bit_cnt;

   logic shift_cmd, shift_data, load_sr, commit, clr_cnt, abort;

   logic [DATA_W-1:0] cfg_q, led_q;
   logic [DATA_W-1:0] data_q [N_CH];
   logic [DATA_W-1:0] en_q   [N_CH];
   logic [DATA_W-1:0] rd_data;
   logic              wr_cfg, wr_led, wr_ok;
   logic [N_CH-1:0]   wr_data, wr_en;

   logic              wr_strobe_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        err_q;

   // Synchronisers clear to 0 so that a CS already low when reset releases is
   // not mistaken for a new frame: only a genuine high-to-low transition starts one.
   // NOTE: clocked state is always assigned with <=, so every flop sees pre-edge values.
   always_ff @(posedge theClock) begin
      if (theReset) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         sdi_sync  <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[0], MySPI_clk};
         cs_sync   <= {cs_sync[0], MySPI_cs};
         sdi_sync  <= {sdi_sync[0], MySPI_sdi};
         sclk_prev <= sclk_sync[1];
         cs_prev   <= cs_sync[1];
      end
   end

   assign sclk_rise = sclk_sync[1] & ~sclk_prev;
   assign cs_high   = cs_sync[1];
   assign cs_fall   = ~cs_sync[1] & cs_prev;
   assign sdi_s     = sdi_sync[1];

   always_ff @(posedge theClock) begin
      if (theReset) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // CS is tested before the SCLK edge, so an edge arriving together with the
   // CS rise is dropped and the word counts as aborted.
   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      shift_cmd  = 1'b0;
      shift_data = 1'b0;
      load_sr    = 1'b0;
      commit     = 1'b0;
      clr_cnt    = 1'b0;
      abort      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cs_fall) begin
               state_d = S_CMD;
               clr_cnt = 1'b1;
            end
         end
         S_CMD: begin
            if (cs_high) begin
               state_d = S_IDLE;
               abort   = (bit_cnt != '0);
            end else if (sclk_rise) begin
               shift_cmd = 1'b1;
               if (bit_cnt == CNT_W'(CMD_BITS - 1)) state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (cs_high) begin
               state_d = S_IDLE;
            end else begin
               load_sr = 1'b1;
               clr_cnt = 1'b1;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (cs_high) begin
               state_d = S_IDLE;
               abort   = (bit_cnt != '0);
            end else if (sclk_rise) begin
               shift_data = 1'b1;
               if (bit_cnt == CNT_W'(DATA_W - 1)) state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            commit  = 1'b1;
            state_d = cs_high ? S_IDLE : S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The R/W bit enters at the bottom of {rw, addr} and reaches the top after CMD_BITS shifts.
   always_ff @(posedge theClock) begin
      if (theReset) begin
         rw_q    <= 1'b0;
         addr_q  <= '0;
         sr_q    <= '0;
         bit_cnt <= '0;
      end else begin
         if (clr_cnt)                      bit_cnt <= '0;
         else if (shift_cmd || shift_data) bit_cnt <= bit_cnt + CNT_W'(1);

         if (shift_cmd)   {rw_q, addr_q} <= {addr_q, sdi_s};
         else if (commit) addr_q         <= addr_q + ADDR_W'(1);

         if (load_sr)         sr_q <= rd_data;
         else if (shift_data) sr_q <= {sr_q[DATA_W-2:0], sdi_s};
      end
   end

   assign MySPI_sdo = sr_q[DATA_W-1];

   always_comb begin
      rd_data = '0;
      wr_cfg  = 1'b0;
      wr_led  = 1'b0;
      wr_data = '0;
      wr_en   = '0;
      if (addr_q == ADDR_W'(0)) begin
         rd_data = cfg_q;
         wr_cfg  = 1'b1;
      end
      if (addr_q == ADDR_W'(1)) rd_data = Status;
      if (addr_q == ADDR_W'(2)) begin
         rd_data = led_q;
         wr_led  = 1'b1;
      end
      for (int c = 0; c < N_CH; c++) begin
         if (addr_q == ADDR_W'(IO_BASE + 2 * c)) begin
            rd_data    = IO_Data_In[c*DATA_W +: DATA_W];
            wr_data[c] = 1'b1;
         end
         if (addr_q == ADDR_W'(IO_BASE + 2 * c + 1)) begin
            rd_data  = en_q[c];
            wr_en[c] = 1'b1;
         end
      end
      wr_ok = wr_cfg | wr_led | (|wr_data) | (|wr_en);
   end

   // NOTE: the register file drives ports whose reset value is 0, so it is reset like any other state.
   always_ff @(posedge theClock) begin
      if (theReset) begin
         cfg_q <= '0;
         led_q <= '0;
         for (int c = 0; c < N_CH; c++) begin
            data_q[c] <= '0;
            en_q[c]   <= '0;
         end
      end else if (commit && rw_q) begin
         if (wr_cfg) cfg_q <= sr_q;
         if (wr_led) led_q <= sr_q;
         for (int c = 0; c < N_CH; c++) begin
            if (wr_data[c]) data_q[c] <= sr_q;
            if (wr_en[c])   en_q[c]   <= sr_q;
         end
      end
   end

   always_ff @(posedge theClock) begin
      if (theReset) begin
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         err_q       <= '0;
      end else begin
         wr_strobe_q <= commit & rw_q & wr_ok;
         if (commit && rw_q && wr_ok) wr_addr_q <= addr_q;
         if (abort && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      end
   end

   assign Config        = cfg_q;
   assign Led70         = led_q;
   assign Wr_Strobe     = wr_strobe_q;
   assign Wr_Addr       = wr_addr_q;
   assign Frame_Err_Cnt = err_q;

   for (genvar c = 0; c < N_CH; c++) begin : g_pack
      assign IO_Data_Out[c*DATA_W +: DATA_W]   = data_q[c];
      assign IO_Enable_Out[c*DATA_W +: DATA_W] = en_q[c];
   end

endmodule

// File: tb/tb_spi_regbank_burst.sv
// Directed bench for spi_regbank_burst: a host model drives mode-0 frames, and scoreboard
// queues hold the expected MISO words and write-strobe addresses.
module tb_spi_regbank_burst;

   localparam int HALF = 6;

   logic          theClock = 1'b0;
   logic          theReset = 1'b1;
   logic          MySPI_clk = 1'b0;
   logic          MySPI_cs = 1'b1;
   logic          MySPI_sdi = 1'b0;
   logic          MySPI_sdo;
   logic [15:0]   Config, Status, Led70;
   logic [287:0]  IO_Data_In, IO_Data_Out, IO_Enable_Out;
   logic          Wr_Strobe;
   logic [14:0]   Wr_Addr;
   logic [7:0]    Frame_Err_Cnt;

   int tests = 0;
   int fails = 0;
   int unexpected = 0;
   logic [15:0] rd_q [$];
   logic [14:0] wr_q [$];

   spi_regbank_burst dut (
      .theClock(theClock), .theReset(theReset),
      .MySPI_clk(MySPI_clk), .MySPI_cs(MySPI_cs), .MySPI_sdi(MySPI_sdi), .MySPI_sdo(MySPI_sdo),
      .Config(Config), .Status(Status), .Led70(Led70),
      .IO_Data_In(IO_Data_In), .IO_Data_Out(IO_Data_Out), .IO_Enable_Out(IO_Enable_Out),
      .Wr_Strobe(Wr_Strobe), .Wr_Addr(Wr_Addr), .Frame_Err_Cnt(Frame_Err_Cnt)
   );

   always #5 theClock = ~theClock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every strobe must match the next queued address; strobes with nothing queued are counted.
   always @(negedge theClock) begin
      if (Wr_Strobe === 1'b1) begin
         if (wr_q.size() > 0) check("wr_addr", {17'd0, Wr_Addr}, {17'd0, wr_q.pop_front()});
         else                 unexpected++;
      end
   end

   task automatic spi_bit(input logic b, output logic so);
      @(negedge theClock);
      MySPI_sdi = b;
      repeat (HALF) @(negedge theClock);
      so = MySPI_sdo;
      MySPI_clk = 1'b1;
      repeat (HALF) @(negedge theClock);
      MySPI_clk = 1'b0;
   endtask

   task automatic spi_cmd(input logic rw, input logic [14:0] a);
      logic [15:0] c;
      logic so;
      c = {rw, a};
      for (int i = 15; i >= 0; i--) spi_bit(c[i], so);
   endtask

   task automatic spi_word(input logic [15:0] w, input logic [15:0] exp_rd);
      logic [15:0] got;
      logic so;
      rd_q.push_back(exp_rd);
      for (int i = 15; i >= 0; i--) begin
         spi_bit(w[i], so);
         got[i] = so;
      end
      check("sdo_word", {16'd0, got}, {16'd0, rd_q.pop_front()});
   endtask

   task automatic frame_begin();
      @(negedge theClock);
      MySPI_cs = 1'b0;
      repeat (HALF) @(negedge theClock);
   endtask

   task automatic frame_end();
      repeat (HALF) @(negedge theClock);
      MySPI_cs = 1'b1;
      repeat (10) @(negedge theClock);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_config"}, {16'd0, Config}, 32'd0);
      check({tag, "_led"}, {16'd0, Led70}, 32'd0);
      check({tag, "_dout"}, {31'd0, |IO_Data_Out}, 32'd0);
      check({tag, "_enout"}, {31'd0, |IO_Enable_Out}, 32'd0);
      check({tag, "_strobe"}, {31'd0, Wr_Strobe}, 32'd0);
      check({tag, "_wraddr"}, {17'd0, Wr_Addr}, 32'd0);
      check({tag, "_errcnt"}, {24'd0, Frame_Err_Cnt}, 32'd0);
      check({tag, "_sdo"}, {31'd0, MySPI_sdo}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic so;
      Status = 16'hBEEF;
      for (int c = 0; c < 18; c++) IO_Data_In[c*16 +: 16] = 16'hC000 + 16'(c);

      repeat (3) @(negedge theClock);
      theReset = 1'b0;
      repeat (4) @(negedge theClock);
      check_zero("reset");

      // Single write to Config; MISO carries the pre-write value.
      wr_q.push_back(15'h0000);
      frame_begin();
      spi_cmd(1'b1, 15'h0000);
      spi_word(16'h1234, 16'h0000);
      frame_end();
      check("write_config", {16'd0, Config}, 32'h1234);
      check("write_errcnt", {24'd0, Frame_Err_Cnt}, 32'd0);

      // Reads: Status alone, then a burst from address 0.
      frame_begin();
      spi_cmd(1'b0, 15'h0001);
      spi_word(16'h0000, 16'hBEEF);
      frame_end();
      frame_begin();
      spi_cmd(1'b0, 15'h0000);
      spi_word(16'h0000, 16'h1234);
      spi_word(16'h0000, 16'hBEEF);
      spi_word(16'h0000, 16'h0000);
      frame_end();

      // Burst write into channel 0 data/enable and channel 1 data.
      wr_q.push_back(15'h0010);
      wr_q.push_back(15'h0011);
      wr_q.push_back(15'h0012);
      frame_begin();
      spi_cmd(1'b1, 15'h0010);
      spi_word(16'hAAAA, 16'hC000);
      spi_word(16'h00FF, 16'h0000);
      spi_word(16'h5555, 16'hC001);
      frame_end();
      check("burst_dout0", {16'd0, IO_Data_Out[15:0]}, 32'hAAAA);
      check("burst_en0", {16'd0, IO_Enable_Out[15:0]}, 32'h00FF);
      check("burst_dout1", {16'd0, IO_Data_Out[31:16]}, 32'h5555);
      check("burst_pending", wr_q.size(), 32'd0);

      frame_begin();
      spi_cmd(1'b0, 15'h0011);
      spi_word(16'h0000, 16'h00FF);
      spi_word(16'h0000, 16'hC001);
      spi_word(16'h0000, 16'h0000);
      frame_end();

      // Abort in the data phase after 9 bits.
      frame_begin();
      spi_cmd(1'b1, 15'h0002);
      for (int i = 0; i < 9; i++) spi_bit(1'b1, so);
      frame_end();
      check("abort_led", {16'd0, Led70}, 32'd0);
      check("abort_errcnt", {24'd0, Frame_Err_Cnt}, 32'd1);

      wr_q.push_back(15'h0002);
      frame_begin();
      spi_cmd(1'b1, 15'h0002);
      spi_word(16'h0F0F, 16'h0000);
      frame_end();
      check("after_abort_led", {16'd0, Led70}, 32'h0F0F);
      check("after_abort_errcnt", {24'd0, Frame_Err_Cnt}, 32'd1);

      // Abort inside the command, then a clean command-only frame.
      frame_begin();
      for (int i = 0; i < 5; i++) spi_bit(1'b1, so);
      frame_end();
      check("cmd_abort_errcnt", {24'd0, Frame_Err_Cnt}, 32'd2);
      frame_begin();
      spi_cmd(1'b0, 15'h0000);
      frame_end();
      check("zero_word_errcnt", {24'd0, Frame_Err_Cnt}, 32'd2);

      // Address wrap: 0x7FFF is unmapped, the second word lands in Config.
      wr_q.push_back(15'h0000);
      frame_begin();
      spi_cmd(1'b1, 15'h7FFF);
      spi_word(16'h1111, 16'h0000);
      spi_word(16'h2222, 16'h1234);
      frame_end();
      check("wrap_config", {16'd0, Config}, 32'h2222);

      // Last channel enable, then the first address past the map.
      wr_q.push_back(15'h0033);
      frame_begin();
      spi_cmd(1'b1, 15'h0033);
      spi_word(16'h1717, 16'h0000);
      spi_word(16'h9999, 16'h0000);
      frame_end();
      check("last_en", {16'd0, IO_Enable_Out[17*16 +: 16]}, 32'h1717);
      check("last_dout", {16'd0, IO_Data_Out[17*16 +: 16]}, 32'h0000);
      check("map_pending", wr_q.size(), 32'd0);
      check("map_unexpected", unexpected, 32'd0);

      // Reset after 20 bits of a write frame; the host then finishes the frame.
      frame_begin();
      spi_cmd(1'b1, 15'h0002);
      for (int i = 0; i < 4; i++) spi_bit(1'b1, so);
      theReset = 1'b1;
      @(negedge theClock);
      theReset = 1'b0;
      @(negedge theClock);
      check_zero("midreset");
      for (int i = 0; i < 12; i++) spi_bit(1'b1, so);
      frame_end();
      check("midreset_led", {16'd0, Led70}, 32'd0);
      check("midreset_errcnt", {24'd0, Frame_Err_Cnt}, 32'd0);
      check("midreset_unexpected", unexpected, 32'd0);

      wr_q.push_back(15'h0002);
      frame_begin();
      spi_cmd(1'b1, 15'h0002);
      spi_word(16'h4321, 16'h0000);
      frame_end();
      check("post_reset_led", {16'd0, Led70}, 32'h4321);

      // 256 one-bit aborts must saturate the counter at 255.
      for (int n = 0; n < 256; n++) begin
         frame_begin();
         spi_bit(1'b1, so);
         frame_end();
      end
      check("err_saturate", {24'd0, Frame_Err_Cnt}, 32'd255);
      check("final_pending", wr_q.size(), 32'd0);
      check("final_unexpected", unexpected, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_regbank_burst.md
Name: spi_regbank_burst

Overview:
Parameterised SPI-slave register bank: next generation of the DE0-nano SPI peripheral for the sandbot I/O expansion. A host (SPI mode 0, MSB first) reads and writes a linear map of control registers plus N_CH I/O channels. Each channel has a data word and an output-enable word. New over the previous generation:
- Width, address size and channel count are parameters.
- Multi-word bursts with address auto-increment.
- Full synchronisation of the SPI input pins.
- Aborted-frame detection and counting.
- A write strobe for downstream logic.

Parameters:
DATA_W, 16, register and SPI data word width (bits)
ADDR_W, 15, address field width following the R/W bit
N_CH, 18, number of I/O channels
IO_BASE, 16, address of channel 0 data; channel c data at IO_BASE+2c, enable at IO_BASE+2c+1

Ports:
theClock  in  1  system clock, all logic on its rising edge
theReset  in  1  synchronous, active-high reset
MySPI_clk  in  1  SPI SCLK (asynchronous)
MySPI_cs  in  1  SPI chip select, active low (asynchronous)
MySPI_sdi  in  1  SPI MOSI (asynchronous)
MySPI_sdo  out  1  SPI MISO = shift register MSB
Config  out  DATA_W  R/W register, address 0
Status  in  DATA_W  read-only, address 1
Led70  out  DATA_W  R/W register, address 2
IO_Data_In  in  N_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]; read at data address
IO_Data_Out  out  N_CH*DATA_W  written at data address
IO_Enable_Out  out  N_CH*DATA_W  R/W at enable address
Wr_Strobe  out  1  one-cycle pulse per committed write
Wr_Addr  out  ADDR_W  address of the committed write, valid with Wr_Strobe
Frame_Err_Cnt  out  8  count of aborted frames, saturating at 255

Behaviour:
- Reset values: all outputs 0 (MySPI_sdo 0); FSM to S_IDLE; counters and shift registers cleared. Reset mid-frame abandons the frame without a write. Reset does not increment Frame_Err_Cnt.
- Synchronisation:
  - clk, cs and sdi each pass through a 2-flop synchroniser.
  - Rising edge of SCLK = sync clk is 1 and was 0 on the previous cycle; sample sdi on that cycle.
  - Requirement on the host: SCLK high and low each ≥ 4 theClock cycles.
- Frame format:
  - CS falls.
  - 1 R/W bit (1 = write).
  - ADDR_W address bits, MSB first.
  - Then any number of DATA_W-bit words until CS rises.
- FSM states:
  - S_IDLE: wait for CS low → S_CMD; bit counter = 0.
  - S_CMD: shift sdi into {rw, addr} on each rising edge. After ADDR_W+1 bits → S_LOAD.
  - S_LOAD (1 cycle): load the shift register with the read value of addr; bit counter = 0 → S_DATA.
  - S_DATA: on each rising edge, shift register <= {shift[DATA_W-2:0], sdi}. After the DATA_W-th bit → S_COMMIT.
  - S_COMMIT (1 cycle):
    - If rw = 1 and addr is writable: write the shift register to the target and pulse Wr_Strobe with Wr_Addr = addr.
    - Then addr <= addr+1, wrapping 2^ADDR_W-1 → 0 → S_LOAD.
- CS high in any state other than S_IDLE returns the FSM to S_IDLE next cycle.
  - If CS rises in S_CMD or S_DATA with bit counter ≠ 0 (partial command or word): frame is aborted, no write occurs, Frame_Err_Cnt increments (saturating).
  - CS rising at a word boundary (bit counter = 0, including 0 words) is a clean end.
- Full duplex: during write words, sdo shifts out the pre-write value of the addressed register.
- Read map:
  - Address 0 → Config; 1 → Status; 2 → Led70.
  - Data address → IO_Data_In[c]; enable address → IO_Enable_Out[c].
  - All other addresses read 0.
- Write map: Config, Led70, IO_Data_Out[c], IO_Enable_Out[c]. Writes to Status or unmapped addresses are ignored: no Wr_Strobe. Address decode uses all ADDR_W bits.
- Simultaneous events: theReset dominates CS and SCLK events. A CS rise and the last data edge on the same cycle count as a clean end only if the edge was sampled first (edge before CS in synchroniser order).

Test Plan:
- Write frame: rw=1, addr 0x0000, data 0x1234 → Config = 0x1234 two cycles after the 16th rising edge; single Wr_Strobe with Wr_Addr = 0; Frame_Err_Cnt = 0.
- Read frame: Status = 0xBEEF; rw=0, addr 0x0001, 16 clocks → sdo bits on host = 0xBEEF; no Wr_Strobe.
- Burst write: addr 0x0010, words 0xAAAA, 0x00FF, 0x5555 → IO_Data_Out ch0 = 0xAAAA, IO_Enable_Out ch0 = 0x00FF, IO_Data_Out ch1 = 0x5555; 3 strobes with Wr_Addr 0x10, 0x11, 0x12.
- Abort: write to addr 2, CS raised after 9 data bits → Led70 unchanged (0), Frame_Err_Cnt = 1; next full frame succeeds.
- Wrap and unmapped: write burst at addr 0x7FFF, words 0x1111, 0x2222 → 0x7FFF ignored, no strobe; Config = 0x2222, strobe Wr_Addr = 0.
- Reset mid-frame: theReset high for 1 cycle after 20 bits of a write frame → all outputs 0, FSM idle, Frame_Err_Cnt 0; no write when the host completes the frame. Next CS-fall frame works.
